// File: rtl/mcpu_io_if.sv
// ---------------------------------------------------------------------------
// mcpu_io_if : main-CPU bus as seen by the I/O block.
//
// Signals
//   cen       main-CPU cycle enable (one clk_sys pulse per CPU cycle)
//   cpu_ab    CPU address bus
//   cpu_dout  CPU write data
//   rw        1 = read, 0 = write
//   io_dout   read data returned by the I/O block
//   io_sel    high while cpu_ab/rw address a readable I/O location
//
// Modports
//   master  CPU side   (drives cen/cpu_ab/cpu_dout/rw, receives io_dout/io_sel)
//   slave   I/O block  (the reverse)
// ---------------------------------------------------------------------------
interface mcpu_io_if;
    logic        cen;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_dout;
    logic        rw;
    logic [7:0]  io_dout;
    logic        io_sel;

    modport master (
        output cen,
        output cpu_ab,
        output cpu_dout,
        output rw,
        input  io_dout,
        input  io_sel
    );

    modport slave (
        input  cen,
        input  cpu_ab,
        input  cpu_dout,
        input  rw,
        output io_dout,
        output io_sel
    );
endinterface

// File: rtl/mcpu_io.sv
// ---------------------------------------------------------------------------
// mcpu_io : main-CPU I/O block.
//
// Decodes CPU writes into the sound latch (with IRQ/overrun handshake),
// NMI-clear strobe, 9-bit horizontal scroll, screen flip and watchdog kick,
// and returns the player/DIP/status inputs on CPU reads.
//
// Optional feature: define MCPU_IO_WATCHDOG_EN to build the frame watchdog.
// Without it wd_reset is tied low and writes to 0x2500 do nothing.
//
// Ports
//   clk_sys    system clock, all state on its rising edge
//   reset_n    asynchronous active-low reset
//   bus        CPU bus (mcpu_io_if.slave): cen, cpu_ab, cpu_dout, rw,
//              io_dout, io_sel
//   p1, p2     player inputs (active-low)
//   dsw0, dsw1 DIP switch banks (active-low; dsw1 is not CPU-readable here)
//   coin       coin inputs (active-low)
//   vblk       vertical blank
//   nmi_clear  one-cycle strobe after a write to 0x2200
//   snd_latch  sound command latch
//   snd_irq    sound-CPU interrupt request
//   snd_ack    sound-CPU latch-read strobe, clears snd_irq
//   scroll_x   horizontal scroll
//   flip       screen flip
//   wd_reset   watchdog reset pulse (active-high, 16 cycles)
//
// Parameter
//   WD_FRAMES  vblank rising edges without a kick before the watchdog fires
// ---------------------------------------------------------------------------
module mcpu_io #(
    parameter int WD_FRAMES = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    mcpu_io_if.slave    bus,
    input  logic [7:0]  p1,
    input  logic [7:0]  p2,
    input  logic [7:0]  dsw0,
    input  logic [7:0]  dsw1,
    input  logic [1:0]  coin,
    input  logic        vblk,
    output logic        nmi_clear,
    output logic [7:0]  snd_latch,
    output logic        snd_irq,
    input  logic        snd_ack,
    output logic [8:0]  scroll_x,
    output logic        flip,
    output logic        wd_reset
);

    localparam logic [15:0] ADDR_SND      = 16'h2100;
    localparam logic [15:0] ADDR_NMI_CLR  = 16'h2200;
    localparam logic [15:0] ADDR_SCROLL_L = 16'h2300;
    localparam logic [15:0] ADDR_SCROLL_H = 16'h2301;
    localparam logic [15:0] ADDR_FLIP     = 16'h2400;
    localparam logic [15:0] ADDR_STATUS   = 16'h3803;

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    logic wr_en;
    logic wr_snd;
    logic wr_nmi;
    logic wr_scroll_lo;
    logic wr_scroll_hi;
    logic wr_flip;
    logic rd_status;

    assign wr_en        = bus.cen & ~bus.rw;
    assign wr_snd       = wr_en && (bus.cpu_ab == ADDR_SND);
    assign wr_nmi       = wr_en && (bus.cpu_ab == ADDR_NMI_CLR);
    assign wr_scroll_lo = wr_en && (bus.cpu_ab == ADDR_SCROLL_L);
    assign wr_scroll_hi = wr_en && (bus.cpu_ab == ADDR_SCROLL_H);
    assign wr_flip      = wr_en && (bus.cpu_ab == ADDR_FLIP);
    // A real CPU read of the status port (cen high) is what acknowledges
    // the overrun flag; idle address decoding does not.
    assign rd_status    = bus.cen && bus.rw && (bus.cpu_ab == ADDR_STATUS);

    // dsw1 has no CPU-visible location in this block.
    logic unused_dsw1;
    assign unused_dsw1 = ^dsw1;

    // -----------------------------------------------------------------------
    // Write-side registers
    // -----------------------------------------------------------------------
    logic [7:0] snd_latch_q, snd_latch_d;
    logic       snd_irq_q,   snd_irq_d;
    logic       overrun_q,   overrun_d;
    logic [8:0] scroll_x_q,  scroll_x_d;
    logic       flip_q,      flip_d;
    logic       nmi_clear_q, nmi_clear_d;

    always_comb begin
        snd_latch_d = snd_latch_q;
        snd_irq_d   = snd_irq_q;
        overrun_d   = overrun_q;
        scroll_x_d  = scroll_x_q;
        flip_d      = flip_q;
        nmi_clear_d = wr_nmi;

        // Sound handshake: a new command beats an acknowledge on the same
        // edge, so the sound CPU never misses the most recent write.
        if (wr_snd) begin
            snd_latch_d = bus.cpu_dout;
            snd_irq_d   = 1'b1;
            if (snd_irq_q) begin
                overrun_d = 1'b1;
            end
        end else if (snd_ack) begin
            snd_irq_d = 1'b0;
        end

        // The read itself still returns the set flag; it drops afterwards.
        if (rd_status) begin
            overrun_d = 1'b0;
        end

        if (wr_scroll_lo) begin
            scroll_x_d[7:0] = bus.cpu_dout;
        end
        if (wr_scroll_hi) begin
            scroll_x_d[8] = bus.cpu_dout[0];
        end
        if (wr_flip) begin
            flip_d = bus.cpu_dout[0];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            snd_latch_q <= 8'h00;
            snd_irq_q   <= 1'b0;
            overrun_q   <= 1'b0;
            scroll_x_q  <= 9'h000;
            flip_q      <= 1'b0;
            nmi_clear_q <= 1'b0;
        end else begin
            snd_latch_q <= snd_latch_d;
            snd_irq_q   <= snd_irq_d;
            overrun_q   <= overrun_d;
            scroll_x_q  <= scroll_x_d;
            flip_q      <= flip_d;
            nmi_clear_q <= nmi_clear_d;
        end
    end

    assign snd_latch = snd_latch_q;
    assign snd_irq   = snd_irq_q;
    assign scroll_x  = scroll_x_q;
    assign flip      = flip_q;
    assign nmi_clear = nmi_clear_q;

    // -----------------------------------------------------------------------
    // Read mux (combinational)
    // -----------------------------------------------------------------------
    always_comb begin
        bus.io_sel  = 1'b0;
        bus.io_dout = 8'hFF;
        // 0x3800..0x3803 share the upper 14 address bits.
        if (bus.rw && (bus.cpu_ab[15:2] == 14'h0E00)) begin
            bus.io_sel = 1'b1;
            case (bus.cpu_ab[1:0])
                2'd0:    bus.io_dout = p1;
                2'd1:    bus.io_dout = p2;
                2'd2:    bus.io_dout = dsw0;
                default: bus.io_dout = {overrun_q, vblk, 4'b1111, coin};
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Frame watchdog
    // -----------------------------------------------------------------------
`ifdef MCPU_IO_WATCHDOG_EN
    localparam logic [15:0] ADDR_WD_KICK = 16'h2500;
    localparam int          WD_CW        = $clog2(WD_FRAMES + 1);

    typedef enum logic {
        WD_COUNT,
        WD_FIRE
    } wd_state_t;

    wd_state_t        wd_state_q, wd_state_d;
    logic [WD_CW-1:0] wd_cnt_q,   wd_cnt_d;
    logic [3:0]       wd_pulse_q, wd_pulse_d;
    logic             vblk_prev_q;
    logic             vblk_rise;
    logic             wr_kick;

    assign wr_kick   = wr_en && (bus.cpu_ab == ADDR_WD_KICK);
    assign vblk_rise = vblk & ~vblk_prev_q;

    always_comb begin
        wd_state_d = wd_state_q;
        wd_cnt_d   = wd_cnt_q;
        wd_pulse_d = wd_pulse_q;

        case (wd_state_q)
            WD_COUNT: begin
                // A kick on the same edge as a vblank edge still zeroes.
                if (wr_kick) begin
                    wd_cnt_d = '0;
                end else if (vblk_rise) begin
                    if (wd_cnt_q == WD_CW'(WD_FRAMES - 1)) begin
                        wd_state_d = WD_FIRE;
                        wd_cnt_d   = '0;
                        wd_pulse_d = 4'd15;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
                end
            end
            WD_FIRE: begin
                // Pulse length is fixed; kicks and vblank edges are ignored
                // until it ends, and counting resumes from zero.
                wd_cnt_d = '0;
                if (wd_pulse_q == 4'd0) begin
                    wd_state_d = WD_COUNT;
                end else begin
                    wd_pulse_d = wd_pulse_q - 4'd1;
                end
            end
            default: begin
                wd_state_d = WD_COUNT;
                wd_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wd_state_q  <= WD_COUNT;
            wd_cnt_q    <= '0;
            wd_pulse_q  <= 4'd0;
            vblk_prev_q <= 1'b0;
        end else begin
            wd_state_q  <= wd_state_d;
            wd_cnt_q    <= wd_cnt_d;
            wd_pulse_q  <= wd_pulse_d;
            vblk_prev_q <= vblk;
        end
    end

    assign wd_reset = (wd_state_q == WD_FIRE);
`else
    // No watchdog: the frame limit is accepted but has no effect.
    logic [31:0] unused_wd_frames;
    assign unused_wd_frames = WD_FRAMES;
    assign wd_reset         = 1'b0;
`endif

endmodule

// File: doc/mcpu_io.md
MCPU_IO -- requirements
Module: mcpu_io

Interface
REQ-001 SHALL have parameter WD_FRAMES, default 16: consecutive vblank rising edges without a watchdog kick before watchdog reset fires.
REQ-002 SHALL have port clk_sys, input, 1: system clock; all state on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port cen, input, 1: main-CPU cycle enable, one clk_sys pulse per CPU cycle.
REQ-005 SHALL have ports cpu_ab (input, 16, CPU address), cpu_dout (input, 8, CPU write data) and rw (input, 1, 1=read, 0=write).
REQ-006 SHALL have ports io_dout (output, 8, read data) and io_sel (output, 1, high when cpu_ab is in a readable I/O location).
REQ-007 SHALL have inputs p1, p2, dsw0 and dsw1 (8 each, active-low), coin (2, active-low) and vblk (1, vertical blank).
REQ-008 SHALL have outputs nmi_clear (1, one-clk_sys strobe), snd_latch (8), snd_irq (1) and snd_ack (input, 1, sound-CPU latch-read strobe).
REQ-009 SHALL have outputs scroll_x (9), flip (1) and wd_reset (1, active-high).

Function
REQ-010 Writes SHALL commit only on a clk_sys edge with cen=1 and rw=0; writes with cen=0 SHALL be ignored.
REQ-011 Write map: 0x2100 snd_latch; 0x2200 nmi_clear strobe (data ignored); 0x2300 scroll_x[7:0]; 0x2301 scroll_x[8]=cpu_dout[0]; 0x2400 flip=cpu_dout[0]; 0x2500 watchdog kick. All other addresses SHALL be no-ops.
REQ-012 nmi_clear SHALL be high for exactly one clk_sys cycle, the cycle after the committing edge.
REQ-013 Read map, combinational: 0x3800 p1; 0x3801 p2; 0x3802 dsw0; 0x3803 {overrun, vblk, 4'b1111, coin[1:0]}; io_sel=1 only for 0x3800-0x3803 with rw=1; otherwise io_dout=0xFF.
REQ-014 snd_latch write SHALL set snd_irq=1 at the committing edge; snd_ack SHALL clear snd_irq on the next edge.
REQ-015 Simultaneous snd_latch write and snd_ack: write wins; snd_irq stays 1 and the latch takes the new data.
REQ-016 A snd_latch write while snd_irq=1 SHALL overwrite the latch and set sticky overrun; a read of 0x3803 with cen=1 SHALL clear overrun after the read.
REQ-017 Watchdog: the vblk rising-edge detector SHALL use a registered previous value; each edge increments an internal counter, and any kick zeroes it.
REQ-018 When the counter reaches WD_FRAMES, wd_reset SHALL assert for exactly 16 clk_sys cycles, then the counter SHALL restart from 0.
REQ-019 A kick and a vblk edge on the same edge: the kick wins and the counter becomes 0.
REQ-020 A kick while wd_reset is high SHALL NOT shorten the pulse.

Reset
REQ-021 reset_n low SHALL immediately, without a clock, set snd_latch=0, snd_irq=0, overrun=0, scroll_x=0, flip=0, nmi_clear=0, wd_reset=0, the watchdog counter to 0 and the vblk history to 0.
REQ-022 Reset asserted mid-strobe or mid-wd_reset pulse SHALL terminate it at once; release SHALL not create spurious strobes.

Configuration
REQ-023 Macro MCPU_IO_WATCHDOG_EN defined: watchdog per REQ-017..020.
REQ-024 Macro absent: no watchdog logic, wd_reset tied 0, and 0x2500 writes are no-ops.

Verification
REQ-025 Write 0x5A to 0x2100 with cen=1 -> snd_latch=0x5A and snd_irq=1 next cycle; snd_ack pulse -> snd_irq=0.
REQ-026 Two 0x2100 writes (0x11, 0x22) with no ack -> snd_latch=0x22, 0x3803 bit7=1, then 0 after that read.
REQ-027 Write 0x2200 with cen=0 -> no nmi_clear; with cen=1 -> nmi_clear high exactly 1 cycle.
REQ-028 Write 0x34 to 0x2300 and 0x01 to 0x2301 -> scroll_x=0x134; read 0x3802 with dsw0=0xA5 -> io_dout=0xA5, io_sel=1.
REQ-029 WATCHDOG_EN, 16 vblk edges with no kick -> wd_reset high 16 cycles; kick every 15 frames -> never asserts.
REQ-030 reset_n low during the wd_reset pulse -> all outputs at reset values within the same cycle.
